// File: rtl/fw_wishbone_sram_ctrl_pkg.sv
// fw_wishbone_sram_ctrl_pkg: shared state and owner encodings for the two-port SRAM arbiter
package fw_wishbone_sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_e;
  localparam logic OWNER_T0 = 1'b0;
  localparam logic OWNER_T1 = 1'b1;
endpackage

// File: rtl/fw_wishbone_sram_arb_rr.sv
// fw_wishbone_sram_arb_rr: combinational 2-way round-robin picker, the port not served last wins a tie
module fw_wishbone_sram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  assign valid  = |req;
  assign winner = &req ? !last : req[1];
endmodule

// File: rtl/fw_wishbone_sram_ctrl_arb2.sv
// fw_wishbone_sram_ctrl_arb2: round-robin arbiter sharing one Wishbone SRAM controller between two masters
module fw_wishbone_sram_ctrl_arb2
  import fw_wishbone_sram_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADR_WIDTH-1:0]   t0_adr,
  input  logic [ADR_WIDTH-1:0]   t1_adr,
  input  logic [DAT_WIDTH-1:0]   t0_dat_w,
  input  logic [DAT_WIDTH-1:0]   t1_dat_w,
  output logic [DAT_WIDTH-1:0]   t0_dat_r,
  output logic [DAT_WIDTH-1:0]   t1_dat_r,
  input  logic                   t0_cyc,
  input  logic                   t1_cyc,
  input  logic                   t0_stb,
  input  logic                   t1_stb,
  input  logic                   t0_we,
  input  logic                   t1_we,
  input  logic [DAT_WIDTH/8-1:0] t0_sel,
  input  logic [DAT_WIDTH/8-1:0] t1_sel,
  output logic                   t0_ack,
  output logic                   t1_ack,
  output logic                   t0_err,
  output logic                   t1_err,
  output logic [ADR_WIDTH-1:0]   i_adr,
  output logic [DAT_WIDTH-1:0]   i_dat_w,
  output logic [DAT_WIDTH/8-1:0] i_sel,
  output logic                   i_we,
  output logic                   i_cyc,
  output logic                   i_stb,
  input  logic [DAT_WIDTH-1:0]   i_dat_r,
  input  logic                   i_ack,
  input  logic                   i_err
);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  arb_state_e state;
  logic owner, last, valid, winner, busy, own_cyc, own_stb, timeout, ack_o, err_o;
  logic [WW-1:0] wdog;
  logic [1:0] req;
  assign req     = {t1_cyc & t1_stb, t0_cyc & t0_stb};
  assign own_cyc = owner ? t1_cyc : t0_cyc;
  assign own_stb = owner ? t1_stb : t0_stb;
  assign busy    = state == BUSY;
  // On release the finishing owner becomes "last" so the other port wins a tie in the same edge
  fw_wishbone_sram_arb_rr u_rr (
    .req    (req),
    .last   (state == IDLE ? last : owner),
    .valid  (valid),
    .winner (winner)
  );
  assign i_cyc   = busy & own_cyc;
  assign i_stb   = busy & own_cyc & own_stb;
  assign i_adr   = busy ? (owner ? t1_adr : t0_adr) : '0;
  assign i_dat_w = busy ? (owner ? t1_dat_w : t0_dat_w) : '0;
  assign i_sel   = busy ? (owner ? t1_sel : t0_sel) : '0;
  assign i_we    = busy & (owner ? t1_we : t0_we);
  assign timeout = TIMEOUT > 0 && i_stb && !i_ack && !i_err && wdog == WLIM;
  assign ack_o   = busy & i_ack;
  assign err_o   = (busy & i_err) | timeout;
  assign t0_ack  = ack_o & (owner == OWNER_T0);
  assign t1_ack  = ack_o & (owner == OWNER_T1);
  assign t0_err  = err_o & (owner == OWNER_T0);
  assign t1_err  = err_o & (owner == OWNER_T1);
  assign t0_dat_r = i_dat_r;
  assign t1_dat_r = i_dat_r;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= OWNER_T0;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      if (state == IDLE || !own_cyc) begin
        if (state != IDLE) last <= owner;
        state <= valid ? BUSY : IDLE;
        if (valid) owner <= winner;
      end else if (timeout) begin
        state <= ABORT;
      end
      wdog <= (TIMEOUT > 0 && i_stb && !i_ack && !i_err && !timeout) ? wdog + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_fw_wishbone_sram_ctrl_arb2.sv
// tb_fw_wishbone_sram_ctrl_arb2: directed scenario bench for the two-port round-robin SRAM arbiter
module tb_fw_wishbone_sram_ctrl_arb2;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [31:0] t0_adr = '0, t1_adr = '0, t0_dat_w = '0, t1_dat_w = '0, t0_dat_r, t1_dat_r;
  logic t0_cyc = 0, t1_cyc = 0, t0_stb = 0, t1_stb = 0, t0_we = 0, t1_we = 0;
  logic [3:0] t0_sel = '0, t1_sel = '0, i_sel;
  logic t0_ack, t1_ack, t0_err, t1_err, i_we, i_cyc, i_stb;
  logic [31:0] i_adr, i_dat_w, i_dat_r = '0;
  logic i_ack = 0, i_err = 0;
  int pass_cnt = 0, total = 0;

  fw_wishbone_sram_ctrl_arb2 #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .t0_adr(t0_adr), .t1_adr(t1_adr), .t0_dat_w(t0_dat_w), .t1_dat_w(t1_dat_w),
    .t0_dat_r(t0_dat_r), .t1_dat_r(t1_dat_r), .t0_cyc(t0_cyc), .t1_cyc(t1_cyc),
    .t0_stb(t0_stb), .t1_stb(t1_stb), .t0_we(t0_we), .t1_we(t1_we),
    .t0_sel(t0_sel), .t1_sel(t1_sel), .t0_ack(t0_ack), .t1_ack(t1_ack),
    .t0_err(t0_err), .t1_err(t1_err), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_sel(i_sel), .i_we(i_we), .i_cyc(i_cyc), .i_stb(i_stb),
    .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    i_ack = 1; i_err = 1; t0_cyc = 1; t0_stb = 1; t0_we = 1; t0_adr = 32'h5; t0_sel = 4'hF;
    repeat (2) tick;
    settle;
    total++; if (i_cyc !== 1'b0) $display("FAIL rst_i_cyc got %b exp 0", i_cyc); else pass_cnt++;
    total++; if (i_stb !== 1'b0) $display("FAIL rst_i_stb got %b exp 0", i_stb); else pass_cnt++;
    total++; if (i_we !== 1'b0) $display("FAIL rst_i_we got %b exp 0", i_we); else pass_cnt++;
    total++; if (i_adr !== 32'h0) $display("FAIL rst_i_adr got %h exp 0", i_adr); else pass_cnt++;
    total++; if (i_sel !== 4'h0) $display("FAIL rst_i_sel got %h exp 0", i_sel); else pass_cnt++;
    total++; if ({t0_ack, t1_ack, t0_err, t1_err} !== 4'b0) $display("FAIL rst_resp got %b exp 0000", {t0_ack, t1_ack, t0_err, t1_err}); else pass_cnt++;
    i_ack = 0; i_err = 0; t0_cyc = 0; t0_stb = 0; t0_we = 0; t0_adr = '0; t0_sel = '0;
    @(negedge clock);
    reset_n = 1;
    tick;
  endtask

  task automatic test_single_write;
    t0_cyc = 1; t0_stb = 1; t0_we = 1; t0_adr = 32'h10; t0_dat_w = 32'hDEADBEEF; t0_sel = 4'hF;
    settle;
    total++; if (i_cyc !== 1'b0) $display("FAIL wr_latency got i_cyc %b exp 0", i_cyc); else pass_cnt++;
    tick; settle;
    total++; if ({i_cyc, i_stb, i_we} !== 3'b111) $display("FAIL wr_ctrl got %b exp 111", {i_cyc, i_stb, i_we}); else pass_cnt++;
    total++; if (i_adr !== 32'h10) $display("FAIL wr_adr got %h exp 10", i_adr); else pass_cnt++;
    total++; if (i_dat_w !== 32'hDEADBEEF) $display("FAIL wr_dat got %h exp deadbeef", i_dat_w); else pass_cnt++;
    total++; if (i_sel !== 4'hF) $display("FAIL wr_sel got %h exp f", i_sel); else pass_cnt++;
    total++; if (t0_ack !== 1'b0) $display("FAIL wr_early_ack got %b exp 0", t0_ack); else pass_cnt++;
    tick; i_ack = 1; settle;
    total++; if ({t0_ack, t1_ack} !== 2'b10) $display("FAIL wr_ack got %b exp 10", {t0_ack, t1_ack}); else pass_cnt++;
    tick; i_ack = 0; t0_cyc = 0; t0_stb = 0; t0_we = 0; settle;
    total++; if ({t0_ack, t1_ack} !== 2'b00) $display("FAIL wr_ack_once got %b exp 00", {t0_ack, t1_ack}); else pass_cnt++;
    tick; settle;
    total++; if ({i_cyc, i_we, i_adr} !== 34'h0) $display("FAIL wr_idle got %h exp 0", {i_cyc, i_we, i_adr}); else pass_cnt++;
  endtask

  task automatic test_tie_after_reset;
    reset_n = 0; #1;
    @(negedge clock); reset_n = 1;
    tick;
    t0_cyc = 1; t0_stb = 1; t0_adr = 32'h20; t1_cyc = 1; t1_stb = 1; t1_adr = 32'h30;
    tick; settle;
    total++; if (i_adr !== 32'h20) $display("FAIL tie_first got adr %h exp 20", i_adr); else pass_cnt++;
    tick; i_ack = 1; i_dat_r = 32'hAAAA5555; settle;
    total++; if ({t0_ack, t1_ack} !== 2'b10) $display("FAIL tie_t0_ack got %b exp 10", {t0_ack, t1_ack}); else pass_cnt++;
    tick; i_ack = 0; t0_cyc = 0; t0_stb = 0;
    tick; settle;
    total++; if ({i_cyc, i_adr} !== {1'b1, 32'h30}) $display("FAIL tie_handover got %h exp 100000030", {i_cyc, i_adr}); else pass_cnt++;
    tick; i_ack = 1; i_dat_r = 32'h12345678; settle;
    total++; if ({t0_ack, t1_ack} !== 2'b01) $display("FAIL tie_t1_ack got %b exp 01", {t0_ack, t1_ack}); else pass_cnt++;
    total++; if (t1_dat_r !== 32'h12345678) $display("FAIL tie_t1_dat got %h exp 12345678", t1_dat_r); else pass_cnt++;
    tick; i_ack = 0; t1_cyc = 0; t1_stb = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    int n0 = 0, n1 = 0, na = 0;
    logic pst = 0, pak = 0, d0 = 0, d1 = 0;
    t0_adr = 32'h100; t1_adr = 32'h200;
    for (int c = 0; c < 80 && na < 8; c++) begin
      t0_cyc = !d0; t0_stb = !d0; t1_cyc = !d1; t1_stb = !d1; i_ack = pst & !pak;
      settle;
      d0 = t0_ack; d1 = t1_ack;
      if (t0_ack && t1_ack) begin total++; $display("FAIL b2b_dual_ack got 11 exp one-hot"); end
      else if (t0_ack || t1_ack) begin
        total++;
        if (t1_ack !== na[0]) $display("FAIL b2b_order got t%0d exp t%0d at ack %0d", t1_ack, na[0], na);
        else pass_cnt++;
        if (t0_ack) n0++; else n1++;
        na++;
      end
      pst = i_stb; pak = i_ack;
      tick;
    end
    total++; if (n0 !== 4) $display("FAIL b2b_t0_count got %0d exp 4", n0); else pass_cnt++;
    total++; if (n1 !== 4) $display("FAIL b2b_t1_count got %0d exp 4", n1); else pass_cnt++;
    t0_cyc = 0; t0_stb = 0; t1_cyc = 0; t1_stb = 0; i_ack = 0;
    repeat (2) tick;
  endtask

  task automatic test_block_read;
    t1_cyc = 1; t1_stb = 1; t1_adr = 32'h40;
    tick;
    t0_cyc = 1; t0_stb = 1; t0_adr = 32'h50;
    for (int k = 0; k < 4; k++) begin
      t1_adr = 32'h40 + 32'(4 * k); i_ack = 1; i_dat_r = 32'hB0 + 32'(k);
      settle;
      total++; if ({t0_ack, t1_ack} !== 2'b01) $display("FAIL blk_ack%0d got %b exp 01", k, {t0_ack, t1_ack}); else pass_cnt++;
      total++; if (i_adr !== 32'h40 + 32'(4 * k)) $display("FAIL blk_adr%0d got %h exp %h", k, i_adr, 32'h40 + 32'(4 * k)); else pass_cnt++;
      total++; if (t1_dat_r !== 32'hB0 + 32'(k)) $display("FAIL blk_dat%0d got %h exp %h", k, t1_dat_r, 32'hB0 + 32'(k)); else pass_cnt++;
      tick;
    end
    t1_cyc = 0; t1_stb = 0; i_ack = 0; settle;
    total++; if ({i_cyc, t0_ack} !== 2'b00) $display("FAIL blk_release got %b exp 00", {i_cyc, t0_ack}); else pass_cnt++;
    tick; i_ack = 1; i_err = 1; settle;
    total++; if ({i_cyc, i_adr} !== {1'b1, 32'h50}) $display("FAIL blk_t0_grant got %h exp 100000050", {i_cyc, i_adr}); else pass_cnt++;
    total++; if ({t0_ack, t0_err, t1_ack, t1_err} !== 4'b1100) $display("FAIL blk_ack_err got %b exp 1100", {t0_ack, t0_err, t1_ack, t1_err}); else pass_cnt++;
    tick; i_ack = 0; i_err = 0; t0_cyc = 0; t0_stb = 0;
    tick; settle;
    total++; if (i_cyc !== 1'b0) $display("FAIL blk_idle got %b exp 0", i_cyc); else pass_cnt++;
  endtask

  task automatic test_timeout;
    t0_cyc = 1; t0_stb = 1; t0_we = 1; t0_adr = 32'h60;
    tick;
    for (int k = 1; k <= 4; k++) begin
      settle;
      total++; if ({i_stb, t0_err, t1_err} !== {1'b1, 1'(k == 4), 1'b0}) $display("FAIL wd_cycle%0d got %b exp %b", k, {i_stb, t0_err, t1_err}, {1'b1, 1'(k == 4), 1'b0}); else pass_cnt++;
      tick;
    end
    i_ack = 1; settle;
    total++; if ({i_cyc, i_stb} !== 2'b00) $display("FAIL wd_abort_bus got %b exp 00", {i_cyc, i_stb}); else pass_cnt++;
    total++; if ({t0_ack, t0_err} !== 2'b00) $display("FAIL wd_late_ack got %b exp 00", {t0_ack, t0_err}); else pass_cnt++;
    tick; i_ack = 0; t0_cyc = 0; t0_stb = 0; t0_we = 0;
    tick; settle;
    total++; if (i_cyc !== 1'b0) $display("FAIL wd_idle got %b exp 0", i_cyc); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    t0_cyc = 1; t0_stb = 1; t0_adr = 32'h70;
    tick; i_ack = 1; settle;
    total++; if ({i_cyc, t0_ack} !== 2'b11) $display("FAIL mr_busy got %b exp 11", {i_cyc, t0_ack}); else pass_cnt++;
    reset_n = 0; #1;
    total++; if ({i_cyc, i_stb, t0_ack, t1_ack} !== 4'b0) $display("FAIL mr_async got %b exp 0000", {i_cyc, i_stb, t0_ack, t1_ack}); else pass_cnt++;
    total++; if (i_adr !== 32'h0) $display("FAIL mr_adr got %h exp 0", i_adr); else pass_cnt++;
    t0_cyc = 0; t0_stb = 0; i_ack = 0;
    @(negedge clock); reset_n = 1;
    tick;
    t1_cyc = 1; t1_stb = 1; t1_adr = 32'h80; settle;
    total++; if (i_cyc !== 1'b0) $display("FAIL mr_idle got %b exp 0", i_cyc); else pass_cnt++;
    tick; i_ack = 1; settle;
    total++; if ({i_cyc, i_adr} !== {1'b1, 32'h80}) $display("FAIL mr_t1_grant got %h exp 100000080", {i_cyc, i_adr}); else pass_cnt++;
    total++; if ({t0_ack, t1_ack} !== 2'b01) $display("FAIL mr_t1_ack got %b exp 01", {t0_ack, t1_ack}); else pass_cnt++;
    tick; i_ack = 0; t1_cyc = 0; t1_stb = 0;
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_tie_after_reset;
    test_back_to_back;
    test_block_read;
    test_timeout;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
